// File: rtl/dataout_inject_sched.sv
// Round-robin injection scheduler: grants N_SRC dataout buffers slots of up to SLOT words into one port.
// Latency: first flit on out_data_o 4 cycles after an accepted start (select, prime, enable, valid+push).
// Backpressure: out_ready_i low stalls the 4-entry FIFO; buffer enables throttle so no word is lost.
//
// Ports:
//   clk_i, rst_ni            clock (rising edge), asynchronous active-low reset
//   start_i, src_mask_i      run request (accepted in IDLE) and the sources to run
//   buf_enable_o             one-hot or zero enable to the dataout buffers
//   buf_dataout_i/_valid_i   buffer words (source i at [i*DW +: DW]) and their strobes
//   out_data_o/_valid_o      FIFO head flit, FIFO non-empty; pops on out_ready_i
//   grant_id_o               currently or last granted source
//   busy_o, all_done_o       run in progress; run complete (level, until next start)
//   err_o                    sticky: stray strobe from a non-granted source or FIFO overflow
module dataout_inject_sched #(
  parameter int N_SRC = 4,
  parameter int DEPTH = 30,
  parameter int SLOT  = 8,
  parameter int DW    = 20,
  localparam int IW   = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [N_SRC-1:0]   src_mask_i,
  output logic [N_SRC-1:0]   buf_enable_o,
  input  logic [N_SRC*DW-1:0] buf_dataout_i,
  input  logic [N_SRC-1:0]   buf_valid_i,
  output logic [DW-1:0]      out_data_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [IW-1:0]      grant_id_o,
  output logic               busy_o,
  output logic               all_done_o,
  output logic               err_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] SLOT_C  = CW'(SLOT);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam int FD = 4;

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_RUN, S_DRAIN, S_FLUSH} state_t;

  state_t                      state_q;
  logic [N_SRC-1:0]            pending_q, primed_q;
  logic [N_SRC-1:0][CW-1:0]    sent_q;
  logic [CW-1:0]               issued_q;
  logic [IW-1:0]               grant_q, rr_ptr_q;
  logic                        busy_q, done_q, err_q, inflight_q;
  logic [DW-1:0]               mem_q [FD];
  logic [1:0]                  wr_q, rd_q;
  logic [2:0]                  cnt_q;

  logic [IW-1:0]    sel_d;
  logic             found;
  logic [N_SRC-1:0] grant_oh, pending_d;
  logic [CW-1:0]    cur_sent, sent_d;
  logic             room, en_ok, prod_en, slot_end;
  logic             push, pop, full, overflow, do_push, stray;
  logic [DW-1:0]    cap_dat;

  // First pending source at or after rr_ptr, wrapping.
  always_comb begin
    sel_d = rr_ptr_q;
    found = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      if (!found && pending_q[(int'(rr_ptr_q) + k) % N_SRC]) begin
        sel_d = IW'((int'(rr_ptr_q) + k) % N_SRC);
        found = 1'b1;
      end
    end
  end

  assign grant_oh  = N_SRC'(1) << grant_q;
  assign cur_sent  = sent_q[grant_q];
  assign sent_d    = cur_sent + issued_q;
  assign pending_d = (sent_d == DEPTH_C) ? (pending_q & ~grant_oh) : pending_q;
  // Counting the in-flight word keeps total occupancy below FIFO capacity.
  assign room      = (cnt_q + {2'b00, inflight_q}) <= 3'd2;
  assign slot_end  = (issued_q == SLOT_C) || (sent_d == DEPTH_C);
  assign en_ok     = (state_q == S_RUN) && room && (issued_q < SLOT_C) && (sent_d < DEPTH_C);
  // Only an enable to an already-primed buffer yields a word.
  assign prod_en   = en_ok && primed_q[grant_q];

  assign cap_dat   = buf_dataout_i[int'(grant_q)*DW +: DW];
  assign push      = buf_valid_i[grant_q];
  assign stray     = |(buf_valid_i & ~grant_oh);
  assign pop       = out_valid_o && out_ready_i;
  assign full      = (cnt_q == 3'(FD));
  assign overflow  = push && full && !pop;
  assign do_push   = push && !overflow;

  assign buf_enable_o = en_ok ? grant_oh : '0;
  assign out_data_o   = mem_q[rd_q];
  assign out_valid_o  = (cnt_q != 3'd0);
  assign grant_id_o   = grant_q;
  assign busy_o       = busy_q;
  assign all_done_o   = done_q;
  assign err_o        = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      pending_q  <= '0;
      primed_q   <= '0;
      sent_q     <= '0;
      issued_q   <= '0;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      inflight_q <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < FD; i++) mem_q[i] <= '0;
    end else begin
      // Merge FIFO
      if (do_push) begin
        mem_q[wr_q] <= cap_dat;
        wr_q        <= wr_q + 2'd1;
      end
      if (pop) rd_q <= rd_q + 2'd1;
      case ({do_push, pop})
        2'b10:   cnt_q <= cnt_q + 3'd1;
        2'b01:   cnt_q <= cnt_q - 3'd1;
        default: cnt_q <= cnt_q;
      endcase

      inflight_q <= prod_en;
      if (stray || overflow) err_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            pending_q <= src_mask_i;
            if (src_mask_i == '0) begin
              done_q <= 1'b1;
            end else begin
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
              sent_q  <= '0;
              state_q <= S_SELECT;
            end
          end
        end
        S_SELECT: begin
          grant_q  <= sel_d;
          issued_q <= '0;
          state_q  <= S_RUN;
        end
        S_RUN: begin
          if (slot_end) begin
            state_q <= S_DRAIN;
          end else if (en_ok) begin
            if (primed_q[grant_q]) issued_q <= issued_q + CW'(1);
            else                   primed_q[grant_q] <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (!inflight_q) begin
            sent_q[grant_q] <= sent_d;
            rr_ptr_q        <= IW'((int'(grant_q) + 1) % N_SRC);
            pending_q       <= pending_d;
            state_q         <= (pending_d != '0) ? S_SELECT : S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (cnt_q == 3'd0 && !inflight_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
